// File: rtl/pc_gen.sv
// Program-counter generation for the 5-stage MIPS fetch stage.
// Arbitrates sequential fetch, branch/flush redirects and stalls with one buffered branch.
module pc_gen #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_pc,
  input  logic                  branch_flag,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  ce,
  output logic                  misalign_exc
);

  localparam int unsigned PcStep = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD_BR = 2'd2
  } state_e;

  state_e                state, state_nxt;
  logic [DATA_WIDTH-1:0] pend_target, pend_target_nxt;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic                  ce_nxt;
  logic                  misalign_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_target  <= '0;
      pc           <= RESET_VECTOR;
      ce           <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      state        <= state_nxt;
      pend_target  <= pend_target_nxt;
      pc           <= pc_nxt;
      ce           <= ce_nxt;
      misalign_exc <= misalign_nxt;
    end
  end

  // Redirect priority: flush > stall > branch > buffered branch > sequential.
  // Buffered targets keep their raw low bits so misalignment is reported on apply.
  always_comb begin
    state_nxt       = state;
    pend_target_nxt = pend_target;
    pc_nxt          = pc;
    ce_nxt          = ce;
    misalign_nxt    = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = RUN;
        ce_nxt    = 1'b1;
        pc_nxt    = RESET_VECTOR;
      end
      RUN, HOLD_BR: begin
        ce_nxt = 1'b1;
        if (flush) begin
          pc_nxt          = {flush_pc[DATA_WIDTH-1:2], 2'b00};
          misalign_nxt    = |flush_pc[1:0];
          pend_target_nxt = '0;
          state_nxt       = RUN;
        end else if (stall) begin
          if (branch_flag) begin
            pend_target_nxt = branch_target;
            state_nxt       = HOLD_BR;
          end
        end else if (branch_flag) begin
          pc_nxt          = {branch_target[DATA_WIDTH-1:2], 2'b00};
          misalign_nxt    = |branch_target[1:0];
          pend_target_nxt = '0;
          state_nxt       = RUN;
        end else if (state == HOLD_BR) begin
          pc_nxt          = {pend_target[DATA_WIDTH-1:2], 2'b00};
          misalign_nxt    = |pend_target[1:0];
          pend_target_nxt = '0;
          state_nxt       = RUN;
        end else begin
          pc_nxt = pc + DATA_WIDTH'(PcStep);
        end
      end
      default: begin
        state_nxt = IDLE;
        ce_nxt    = 1'b0;
        pc_nxt    = RESET_VECTOR;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed test-plan sequences plus randomized traffic
// against a rule-level reference model of the fetch address stream.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic        ce;
  logic        misalign_exc;

  pc_gen #(.DATA_WIDTH(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .pc(pc), .ce(ce), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        rst_next = 1'b0;

  // Reference model: fetch running flag, current pc, at most one pending branch
  logic        m_run = 1'b0;
  logic [31:0] m_pc = RV;
  logic        m_mis = 1'b0;
  logic [31:0] m_pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_run = 1'b0;
    m_pc  = RV;
    m_mis = 1'b0;
    m_pend.delete();
  endtask

  task automatic m_load(input logic [31:0] t);
    m_pc  = t - (t % 4);
    m_mis = (t % 4) != 0;
  endtask

  task automatic m_step(input logic f, input logic [31:0] fpc, input logic s,
                        input logic bf, input logic [31:0] bt);
    m_mis = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
      m_pc  = RV;
    end else if (f) begin
      m_load(fpc);
      m_pend.delete();
    end else if (s) begin
      if (bf) begin
        m_pend.delete();
        m_pend.push_back(bt);
      end
    end else if (bf) begin
      m_load(bt);
      m_pend.delete();
    end else if (m_pend.size() != 0) begin
      m_load(m_pend.pop_front());
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: drive inputs on the falling edge, predict the post-edge outputs
  task automatic cyc(input logic f, input logic [31:0] fpc, input logic s,
                     input logic bf, input logic [31:0] bt);
    exp_t e;
    @(negedge clk);
    rst_n = rst_next;
    flush = f; flush_pc = fpc; stall = s; branch_flag = bf; branch_target = bt;
    if (rst_n) m_step(f, fpc, s, bf, bt);
    else       m_reset();
    e.pc = m_pc; e.ce = m_run; e.mis = m_mis;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    rst_next = 1'b0;
    #1;
    chk("async_rst_pc", pc, RV);
    chk("async_rst_ce", 32'(ce), 32'd0);
    chk("async_rst_mis", 32'(misalign_exc), 32'd0);
    m_reset();
    idle(2);
    rst_next = 1'b1;
  endtask

  // Monitor: compare each registered output set one step after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pc", pc, e.pc);
        chk("ce", 32'(ce), 32'(e.ce));
        chk("misalign_exc", 32'(misalign_exc), 32'(e.mis));
      end
    end
  end

  initial begin
    logic [31:0] t;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_mis", 32'(misalign_exc), 32'd0);
    idle(2);
    rst_next = 1'b1;

    // Release, then sequential fetch 0,4,8; branch to 0x40
    idle(3);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h40);
    idle(2);

    // Redirect to 0x10, then stall 3 cycles with a branch to 0x80 on the first
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h10);
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h80);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);

    // Flush beats a simultaneous stall+branch
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h20);
    cyc(1'b1, 32'h180, 1'b1, 1'b1, 32'h80);
    idle(2);

    // Misaligned branch, flush onto the wrap boundary
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h43);
    idle(1);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0);
    idle(2);

    // Misaligned branch buffered during stall: flag only when applied
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h1001);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);

    // Async reset mid-stall with a branch buffered
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h300);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    async_reset();
    idle(4);

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 1500; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      cyc($urandom_range(0, 15) == 0, t ^ 32'h0000_1000,
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, t);
      if (i % 500 == 499) async_reset();
    end

    idle(2);
    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
